// File: rtl/sdram_mem_tester.sv
// sdram_mem_tester: bus-master self-test for the SDRAM controller request port.
// It writes pattern(a) = PATTERN_SEED ^ a over [START_ADDR, END_ADDR].
// It then reads the range back and counts mismatches.
// Optional macro SDRAM_TESTER_INVERT_PASS_EN adds a second write/read pass
// using ~pattern(a); errors and the timeout accumulate across both passes.
module sdram_mem_tester #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    START_ADDR     = 0,
    parameter int                    END_ADDR       = 1023,
    parameter logic [DATA_WIDTH-1:0] PATTERN_SEED   = 32'hA5A5_0000,
    parameter int                    TIMEOUT_CYCLES = 4096
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  we_o,
    output logic                  re_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [15:0]           err_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_WRITE  = 4'd1,
        ST_GAP_W  = 4'd2,
        ST_READ   = 4'd3,
        ST_GAP_R  = 4'd4,
`ifdef SDRAM_TESTER_INVERT_PASS_EN
        ST_WRITE2 = 4'd6,
        ST_READ2  = 4'd7,
`endif
        ST_DONE   = 4'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_ADDR);
    localparam logic [31:0]           WAIT_MAX = 32'(TIMEOUT_CYCLES - 1);

    state_t                  r_state,   w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr,    w_addr_next;
    logic [15:0]             r_err,     w_err_next;
    logic [ADDR_WIDTH-1:0]   r_fail,    w_fail_next;
    logic                    r_timeout, w_timeout_next;
    logic [31:0]             r_wait,    w_wait_next;
    logic                    r_inv,     w_inv_next;
    logic                    w_is_rd;
    logic                    w_nx_wr;
    logic                    w_nx_rd;
    logic                    w_nx_gap;

    logic [ADDR_WIDTH-1:0]   r_addr_o;
    logic [DATA_WIDTH-1:0]   r_data_o;
    logic                    r_we_o, r_re_o, r_busy_o, r_done_o, r_pass_o;

    // Expected word: seed XOR zero-extended address, optionally inverted.
    function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [ADDR_WIDTH-1:0] a,
                                                         input logic inv);
        logic [DATA_WIDTH-1:0] p;
        p = PATTERN_SEED ^ DATA_WIDTH'(a);
        return inv ? ~p : p;
    endfunction

    // Next-state, address walk, compare and timeout decisions.
    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_err_next     = r_err;
        w_fail_next    = r_fail;
        w_timeout_next = r_timeout;
        w_wait_next    = r_wait;
        w_inv_next     = r_inv;
        w_is_rd        = (r_state == ST_READ)
`ifdef SDRAM_TESTER_INVERT_PASS_EN
                         || (r_state == ST_READ2)
`endif
                         ;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_state_next   = ST_WRITE;
                    w_addr_next    = START_A;
                    w_err_next     = 16'd0;
                    w_fail_next    = {ADDR_WIDTH{1'b0}};
                    w_timeout_next = 1'b0;
                    w_wait_next    = 32'd0;
                    w_inv_next     = 1'b0;
                end else begin
                    w_state_next   = r_state;
                end
            end
            ST_WRITE, ST_READ
`ifdef SDRAM_TESTER_INVERT_PASS_EN
            , ST_WRITE2, ST_READ2
`endif
            : begin
                if (ack_i) begin
                    if (w_is_rd && (data_i != f_pattern(r_addr, r_inv))) begin
                        if (r_err != 16'hFFFF) begin
                            w_err_next = r_err + 16'd1;
                        end else begin
                            w_err_next = r_err;
                        end
                        if (r_err == 16'd0) begin
                            w_fail_next = r_addr;
                        end else begin
                            w_fail_next = r_fail;
                        end
                    end else begin
                        w_err_next = r_err;
                    end
                    w_state_next = w_is_rd ? ST_GAP_R : ST_GAP_W;
                end else if (r_wait == WAIT_MAX) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = ST_DONE;
                end else begin
                    w_wait_next = r_wait + 32'd1;
                end
            end
            ST_GAP_W: begin
                w_wait_next = 32'd0;
                if (r_addr == END_A) begin
                    w_addr_next = START_A;
`ifdef SDRAM_TESTER_INVERT_PASS_EN
                    w_state_next = r_inv ? ST_READ2 : ST_READ;
`else
                    w_state_next = ST_READ;
`endif
                end else begin
                    w_addr_next = r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`ifdef SDRAM_TESTER_INVERT_PASS_EN
                    w_state_next = r_inv ? ST_WRITE2 : ST_WRITE;
`else
                    w_state_next = ST_WRITE;
`endif
                end
            end
            ST_GAP_R: begin
                w_wait_next = 32'd0;
                if (r_addr == END_A) begin
                    w_addr_next = START_A;
`ifdef SDRAM_TESTER_INVERT_PASS_EN
                    if (!r_inv) begin
                        w_inv_next   = 1'b1;
                        w_state_next = ST_WRITE2;
                    end else begin
                        w_state_next = ST_DONE;
                    end
`else
                    w_state_next = ST_DONE;
`endif
                end else begin
                    w_addr_next = r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`ifdef SDRAM_TESTER_INVERT_PASS_EN
                    w_state_next = r_inv ? ST_READ2 : ST_READ;
`else
                    w_state_next = ST_READ;
`endif
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Decode of the next state so the registered outputs line up with it.
    always_comb begin
        w_nx_wr  = (w_state_next == ST_WRITE)
`ifdef SDRAM_TESTER_INVERT_PASS_EN
                   || (w_state_next == ST_WRITE2)
`endif
                   ;
        w_nx_rd  = (w_state_next == ST_READ)
`ifdef SDRAM_TESTER_INVERT_PASS_EN
                   || (w_state_next == ST_READ2)
`endif
                   ;
        w_nx_gap = (w_state_next == ST_GAP_W) || (w_state_next == ST_GAP_R);
    end

    // State, counters and registered outputs; reset aborts any request at once.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= START_A;
            r_err     <= 16'd0;
            r_fail    <= {ADDR_WIDTH{1'b0}};
            r_timeout <= 1'b0;
            r_wait    <= 32'd0;
            r_inv     <= 1'b0;
            r_addr_o  <= {ADDR_WIDTH{1'b0}};
            r_data_o  <= {DATA_WIDTH{1'b0}};
            r_we_o    <= 1'b0;
            r_re_o    <= 1'b0;
            r_busy_o  <= 1'b0;
            r_done_o  <= 1'b0;
            r_pass_o  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= w_addr_next;
            r_err     <= w_err_next;
            r_fail    <= w_fail_next;
            r_timeout <= w_timeout_next;
            r_wait    <= w_wait_next;
            r_inv     <= w_inv_next;
            r_addr_o  <= w_addr_next;
            r_data_o  <= f_pattern(w_addr_next, w_inv_next);
            r_we_o    <= w_nx_wr;
            r_re_o    <= w_nx_rd;
            r_busy_o  <= w_nx_wr | w_nx_rd | w_nx_gap;
            r_done_o  <= (w_state_next == ST_DONE);
            r_pass_o  <= (w_state_next == ST_DONE) && (w_err_next == 16'd0) && !w_timeout_next;
        end
    end

    assign addr_o      = r_addr_o;
    assign data_o      = r_data_o;
    assign we_o        = r_we_o;
    assign re_o        = r_re_o;
    assign busy_o      = r_busy_o;
    assign done_o      = r_done_o;
    assign pass_o      = r_pass_o;
    assign timeout_o   = r_timeout;
    assign err_count_o = r_err;
    assign fail_addr_o = r_fail;

endmodule

// File: tb/tb_sdram_mem_tester.sv
// Self-checking bench for sdram_mem_tester.
// A behavioural memory responder acks with programmable latency and can inject corruption, a missing ack and stray acks.
// Expected transactions and results are derived from the address range and pattern rule.
module tb_sdram_mem_tester;

    localparam int          DW   = 32;
    localparam int          AW   = 16;
    localparam int          SA   = 0;
    localparam int          EA   = 3;
    localparam int          TO   = 8;
    localparam logic [31:0] SEED = 32'hA5A5_0000;
    localparam int          NW   = EA - SA + 1;
`ifdef SDRAM_TESTER_INVERT_PASS_EN
    localparam int          NPASS = 2;
`else
    localparam int          NPASS = 1;
`endif
    localparam int          NTXN = 2 * NW * NPASS;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          start_i;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_o;
    logic          we_o, re_o;
    logic [DW-1:0] data_i = '0;
    logic          ack_i  = 1'b0;
    logic          busy_o, done_o, pass_o, timeout_o;
    logic [15:0]   err_count_o;
    logic [AW-1:0] fail_addr_o;

    sdram_mem_tester #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_ADDR(SA), .END_ADDR(EA),
        .PATTERN_SEED(SEED), .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start_i(start_i),
        .addr_o(addr_o), .data_o(data_o), .we_o(we_o), .re_o(re_o),
        .data_i(data_i), .ack_i(ack_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .timeout_o(timeout_o), .err_count_o(err_count_o),
        .fail_addr_o(fail_addr_o)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int a, input int p);
        logic [31:0] v;
        v = SEED ^ 32'(a);
        return (p != 0) ? ~v : v;
    endfunction

    // Scenario controls (written only by the main sequence).
    int lat_mode   = 0;
    int noack_addr = -1;
    bit corrupt_en = 1'b0;
    bit stray_en   = 1'b0;
    int tx_base    = 0;
    // Responder statistics (written only by the responder).
    int n_acc = 0, busy_cnt = 0, we_a1_cnt = 0, rd_cnt = 0;
    int cnt = 0, cur_lat = 0, k;
    logic          prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0, prev_re = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] mem [int];

    // Memory responder: decides ack/data for the coming edge, checks handshake rules.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            ack_i    = 1'b0;
            cnt      = 0;
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (busy_o) busy_cnt++;
            if (we_o && addr_o == 16'd1) we_a1_cnt++;
            check_val("excl_we_re", {63'd0, we_o & re_o}, 64'd0);
            if ((we_o | re_o) && prev_req && !prev_ack)
                check_val("stable_req", {14'd0, we_o, re_o, addr_o, (we_o ? data_o : 32'd0)},
                          {14'd0, prev_we, prev_re, prev_addr, (prev_we ? prev_data : 32'd0)});
            if (we_o | re_o) begin
                if (cnt >= cur_lat && !(we_o && noack_addr == int'(addr_o))) begin
                    ack_i = 1'b1;
                    k = n_acc - tx_base;
                    check_val("txn_order",
                              {15'd0, we_o, addr_o, (we_o ? data_o : 32'd0)},
                              {15'd0, ((k % (2*NW)) < NW), 16'(SA + (k % NW)),
                               (((k % (2*NW)) < NW) ? pat(SA + (k % NW), k / (2*NW)) : 32'd0)});
                    n_acc++;
                    if (we_o) begin
                        mem[int'(addr_o)] = data_o;
                    end else begin
                        rd_cnt++;
                        data_i = mem.exists(int'(addr_o)) ? mem[int'(addr_o)] : 32'd0;
                        if (corrupt_en && addr_o == 16'd2) data_i = 32'd0;
                        if (corrupt_en && addr_o == 16'd3) data_i = data_i ^ 32'd1;
                    end
                    cnt     = 0;
                    cur_lat = (lat_mode != 0) ? $urandom_range(0, 5) : 0;
                end else begin
                    ack_i = 1'b0;
                    cnt++;
                end
            end else begin
                ack_i  = stray_en && ($urandom_range(0, 2) == 0);
                data_i = $urandom;
                cnt    = 0;
            end
            prev_req  = we_o | re_o;
            prev_ack  = ack_i;
            prev_we   = we_o;
            prev_re   = re_o;
            prev_addr = addr_o;
            prev_data = data_o;
        end
    end

    int b_acc, b_busy, b_we1, b_rd;

    task automatic kick(input int lm, input bit corr, input int noack, input bit stray);
        @(negedge sys_clk);
        #1;
        lat_mode   = lm;
        corrupt_en = corr;
        noack_addr = noack;
        stray_en   = stray;
        tx_base    = n_acc;
        b_acc      = n_acc;
        b_busy     = busy_cnt;
        b_we1      = we_a1_cnt;
        b_rd       = rd_cnt;
        start_i    = 1'b1;
        @(negedge sys_clk);
        start_i    = 1'b0;
        check_val("start_we", {63'd0, we_o}, 64'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && !done_o; i++) @(negedge sys_clk);
        check_val({tag, "_done"}, {63'd0, done_o}, 64'd1);
    endtask

    task automatic check_result(input string tag, input bit pass, input bit tmo,
                                input int errs, input int faddr, input int nacc);
        check_val({tag, "_pass"},  {63'd0, pass_o},    {63'd0, pass});
        check_val({tag, "_tmo"},   {63'd0, timeout_o}, {63'd0, tmo});
        check_val({tag, "_err"},   {48'd0, err_count_o}, 64'(errs));
        check_val({tag, "_faddr"}, {48'd0, fail_addr_o}, 64'(faddr));
        check_val({tag, "_nacc"},  64'(n_acc - b_acc), 64'(nacc));
        check_val({tag, "_busy0"}, {63'd0, busy_o}, 64'd0);
    endtask

    initial begin
        sys_rst = 1'b1;
        start_i = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_val("rst_ctl", {58'd0, we_o, re_o, busy_o, done_o, pass_o, timeout_o}, 64'd0);
        check_val("rst_bus", {16'd0, addr_o, data_o}, 64'd0);
        check_val("rst_cnt", {32'd0, err_count_o, fail_addr_o}, 64'd0);
        sys_rst = 1'b0;

        // Clean run, zero-latency acks: two cycles per word.
        kick(0, 1'b0, -1, 1'b0);
        wait_done("clean");
        check_result("clean", 1'b1, 1'b0, 0, 0, NTXN);
        check_val("clean_busycyc", 64'(busy_cnt - b_busy), 64'(2 * NTXN));

        // Corrupted reads at addresses 2 and 3.
        kick(0, 1'b1, -1, 1'b0);
        wait_done("corrupt");
        check_result("corrupt", 1'b0, 1'b0, 2 * NPASS, 2, NTXN);

        // Write to address 1 never acked: timeout, no reads.
        kick(0, 1'b0, 1, 1'b0);
        wait_done("timeout");
        check_result("timeout", 1'b0, 1'b1, 0, 0, 1);
        check_val("timeout_wecyc", 64'(we_a1_cnt - b_we1), 64'(TO));
        check_val("timeout_reads", 64'(rd_cnt - b_rd), 64'd0);

        // Random latency with stray acks in gaps and idle.
        for (int r = 0; r < 3; r++) begin
            kick(1, 1'b0, -1, 1'b1);
            wait_done("rand");
            check_result("rand", 1'b1, 1'b0, 0, 0, NTXN);
        end

        // Reset asserted during the read of address 1, then a clean rerun.
        kick(1, 1'b0, -1, 1'b0);
        for (int i = 0; i < 3000 && !(re_o && addr_o == 16'd1); i++) @(negedge sys_clk);
        check_val("rst_mid_reached", {63'd0, re_o}, 64'd1);
        sys_rst = 1'b1;
        #1;
        check_val("rstmid_ctl", {58'd0, we_o, re_o, busy_o, done_o, pass_o, timeout_o}, 64'd0);
        check_val("rstmid_bus", {16'd0, addr_o, data_o}, 64'd0);
        check_val("rstmid_cnt", {32'd0, err_count_o, fail_addr_o}, 64'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        kick(1, 1'b0, -1, 1'b1);
        wait_done("after_rst");
        check_result("after_rst", 1'b1, 1'b0, 0, 0, NTXN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time guard.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdram_mem_tester.md
Name: sdram_mem_tester

Overview:
- Bus master that drives the processor-side request interface of the SDRAM controller (addr/data/we/re out, data/ack in).
- Writes an address-derived pattern across a configurable word range, then reads the range back and checks every word.
- Reports busy, done, pass, error count and first failing address; used as the board-level self-test for the SDRAM bring-up.

Parameters:
- DATA_WIDTH, 32, width of the data bus to and from the controller.
- ADDR_WIDTH, 16, width of the word address bus.
- START_ADDR, 0, first word address tested.
- END_ADDR, 1023, last word address tested, inclusive; must be >= START_ADDR.
- PATTERN_SEED, 32'hA5A5_0000, XOR seed; pattern(a) = PATTERN_SEED ^ zero-extended a.
- TIMEOUT_CYCLES, 4096, maximum cycles a request may wait for ack_i.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- start_i  input  1  level-sampled start request.
- addr_o  output  ADDR_WIDTH  request address.
- data_o  output  DATA_WIDTH  write data.
- we_o  output  1  write request.
- re_o  output  1  read request.
- data_i  input  DATA_WIDTH  read data from the controller, valid when ack_i is high during a read.
- ack_i  input  1  one-cycle completion strobe from the controller.
- busy_o  output  1  test in progress.
- done_o  output  1  test finished; held until the next start.
- pass_o  output  1  valid while done_o is high; 1 = no mismatch and no timeout.
- timeout_o  output  1  sticky flag: a request exceeded TIMEOUT_CYCLES.
- err_count_o  output  16  mismatch count, saturates at 16'hFFFF.
- fail_addr_o  output  ADDR_WIDTH  address of the first mismatch; 0 if no mismatch.

Behaviour:
- Reset: all outputs 0, state IDLE, address counter = START_ADDR. Reset asserted mid-test aborts immediately; requests drop asynchronously.
- States and transitions:
  - IDLE: start_i=1 at edge N -> WRITE, with we_o=1 from edge N+1.
  - WRITE: we_o=1, addr_o=cur, data_o=pattern(cur). On ack_i -> GAP_W.
  - GAP_W: one cycle with requests low. If the last acked address was END_ADDR, address reloads to START_ADDR and next state is READ; otherwise address +1 and next state is WRITE.
  - READ: re_o=1, addr_o=cur. On ack_i, compare data_i to pattern(cur) -> GAP_R.
  - GAP_R: same structure as GAP_W; after END_ADDR go to DONE.
  - DONE: done_o=1, busy_o=0, pass_o = (err_count==0 && !timeout). start_i=1 clears the counters, timeout and fail_addr, then enters WRITE with the same latency as from IDLE.
- busy_o is 1 in WRITE, READ, GAP_W and GAP_R.
- Handshake:
  - A request and its addr_o/data_o stay stable until the cycle ack_i is sampled high.
  - The request drops in the cycle after ack.
  - we_o and re_o are never high together.
  - ack_i is ignored outside WRITE and READ (stray acks are dropped).
  - An ack in the first request cycle is accepted, giving a minimum of 2 cycles per word.
- Mismatch: err_count increments, saturating. fail_addr_o latches only on the first mismatch of a run.
- Timeout: a wait counter clears on each request start. When it reaches TIMEOUT_CYCLES without ack, timeout_o=1, the request drops and the state goes to DONE, so pass_o=0.
- start_i while busy is ignored.
- The address counter is ADDR_WIDTH wide. END_ADDR = 2^ADDR_WIDTH-1 must terminate correctly, so the compare uses equality with END_ADDR, not overflow.

Optional Feature:
- SDRAM_TESTER_INVERT_PASS_EN defined: after the first read pass, a second write and read pass runs over the same range with pattern ~pattern(a). States WRITE2/READ2 reuse the GAP logic. Errors and the timeout accumulate across both passes; DONE is reached after READ2.
- Macro undefined: single pass only; the extra states are not present.

Test Plan:
- Ideal memory model, ack 1 cycle after request, START=0, END=3, pulse start_i:
  - 4 writes with data A5A50000..A5A50003, then 4 reads.
  - done_o=1, pass_o=1, err_count_o=0; busy_o high for exactly 16 cycles.
- Model corrupts read of addr 2 (returns 0) and addr 3:
  - err_count_o=2, fail_addr_o=2, pass_o=0.
- Model never acks addr 1 write, TIMEOUT_CYCLES=8:
  - we_o drops after 8 wait cycles, timeout_o=1, done_o=1, pass_o=0, no reads issued.
- Variable ack latency 0-5 cycles plus stray ack_i pulses during GAP and IDLE:
  - addr_o/data_o stable until ack.
  - Strays ignored.
  - Result pass_o=1.
- Assert sys_rst during READ of addr 1:
  - All outputs 0 immediately.
  - A later start_i runs a full clean test with pass_o=1.
- Macro defined, END=1:
  - Writes A5A50000, A5A50001, then reads.
  - Then writes 5A5AFFFF, 5A5AFFFE, then reads.
  - pass_o=1.
